md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
E-stage multiply/divide unit with architectural HI/LO registers. It sits directly upstream of the M stage: its MFHI/MFLO result joins the E-stage ALU result that the E/M register carries into M.
- Models the multi-cycle latency of MULT/MULTU/DIV/DIVU with a busy counter.
- The hazard unit stalls F/D while busy, or while start is asserted, whenever the instruction in D is an md-class instruction.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal 1..15)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
md_op  input  4  operation from E-stage controller: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; others treated as NONE
start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU and E is not flushed
A  input  32  forwarded rs value (E_Forward1)
B  input  32  forwarded rt value (E_Forward2)
busy  output  1  operation in flight; high while counter != 0
md_out  output  32  HI for MFHI, LO for MFLO, else 0; combinational from HI/LO registers

Behaviour:
- Reset (asserted low, asynchronous): HI=0, LO=0, counter=0, busy=0, pending results=0. An operation in flight is abandoned and HI/LO are not updated.
- Idle (counter=0) with start=1 at edge t:
  - Latch the result into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy is high from after edge t until after edge t+N, where N is the cycle count.
  - At edge t+N, commit HI=pend_hi and LO=pend_lo and set counter to 0.
  - The new HI/LO are visible on md_out from cycle t+N onward.
- States: IDLE (counter=0) and RUN (counter>0, decrement each edge). COMMIT is the edge where counter goes 1->0.
- start while busy: ignored. The hazard unit guarantees this does not occur; the bench checks that HI/LO and counter are unaffected.
- MTHI/MTLO: write A to HI/LO at the edge, only when busy=0 and start=0. They are ignored while busy.
- MFHI/MFLO while busy: md_out still returns the old HI/LO. The stall prevents the consumer from using it.
- Arithmetic, computed on the start cycle from A/B:
  - MULT: {HI,LO} = signed 64-bit A*B.
  - MULTU: {HI,LO} = unsigned 64-bit A*B.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (B=0, DIV/DIVU): runs the full DIV_CYCLES, then HI and LO are left unchanged. No exception.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Commit edge coinciding with a new start or MT* in E: not possible, because busy is high that cycle and they are ignored. The first accepted start is at the edge after the commit.
- busy is a pure function of the counter register, so it has no combinational path from start.
- The hazard unit uses busy|start for the stall.

Decomposition:
- Shared package md_pkg holds:
  - the md_op encodings (MD_NONE..MD_MTLO, 4 bits);
  - MULT_CYCLES/DIV_CYCLES defaults;
  - the 64-bit result width constant.
- The controller decoder and the hazard unit import it.
- One sub-module is natural: md_divider, a combinational signed/unsigned divide with zero and overflow flags. It keeps the special-case rules isolated and testable.
- The multiplier stays inline.

Test Plan:
- MULT, A=0xFFFFFFFE (-2), B=3, start pulse at edge 0:
  - busy=1 after edges 0..4, busy=0 after edge 5;
  - after edge 5, MFHI gives md_out=0xFFFFFFFF and MFLO gives md_out=0xFFFFFFFA;
  - before edge 5, both still read 0.
- DIV A=-7 (0xFFFFFFF9), B=2:
  - after 10 busy cycles, LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
  - Then DIVU with the same operands gives LO=0x7FFFFFFC and HI=1.
- Divide by zero:
  - MTHI 0x1234, MTLO 0x5678, then DIVU with B=0.
  - busy stays high for 10 cycles, then HI=0x1234 and LO=0x5678 are unchanged.
- Overflow: DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Busy interactions:
  - During a MULTU 0xFFFFFFFF*0xFFFFFFFF, assert start with DIV and md_op=MTLO on cycle 2.
  - Both are ignored: counter continues from its current value.
  - Final HI=0xFFFFFFFE, LO=0x00000001.
- Reset mid-operation:
  - Assert reset low asynchronously 3 cycles into a MULT.
  - busy, HI and LO drop to 0 immediately without waiting for a clock edge.
  - After release, a new MTHI 0xAA is accepted on the next edge.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit and its consumers
// (controller decoder, hazard unit).
package md_pkg;

    // md_op encodings driven by the E-stage controller
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;
    localparam int unsigned RESULT_W        = 64;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/md_divider.sv
// Combinational 32-bit signed/unsigned divider with divide-by-zero and
// signed-overflow flags. Quotient truncates toward zero; the remainder takes
// the sign of the dividend.
module md_divider (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero,
    output logic        overflow
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Sign-magnitude divide; divisor forced to 1 on zero so the operator never sees /0
    always_comb begin
        a_neg    = is_signed & a[31];
        b_neg    = is_signed & b[31];
        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
        div_zero = (b == 32'd0);
        overflow = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        divisor  = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / divisor;
        r_mag    = a_mag % divisor;
        quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
        if (div_zero) begin
            quot = 32'd0;
            rem  = 32'd0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, multi-cycle latency model
// via a busy counter, and MFHI/MFLO read mux feeding the E/M result path.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] md_out
);

    md_op_e             op;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;

    logic               idle;
    logic               is_mul;
    logic               is_div;
    logic               accept;
    logic [RESULT_W-1:0] prod_s;
    logic [RESULT_W-1:0] prod_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic [31:0]        div_quot;
    logic [31:0]        div_rem;
    logic               div_zero;
    logic               div_ovf;

    assign op     = md_op_e'(md_op);
    assign idle   = (count_q == '0);
    assign busy   = ~idle;
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
    // start is only honoured from idle; the hazard unit keeps it away otherwise
    assign accept = idle && start && (is_mul || is_div);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    md_divider u_divider (
        .a         (A),
        .b         (B),
        .is_signed (op == MD_DIV),
        .quot      (div_quot),
        .rem       (div_rem),
        .div_zero  (div_zero),
        .overflow  (div_ovf)
    );

    // Result captured on the start cycle; divide by zero re-commits the current HI/LO
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                if (div_zero) begin
                    res_hi = hi_q;
                    res_lo = lo_q;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = div_rem;
                    res_lo = div_quot;
                end
            end
            default: ;
        endcase
    end

    // Next-state: accept from idle, count down while running, commit on 1->0
    always_comb begin
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (accept) begin
            count_d   = is_mul ? MULT_CYCLES[CNT_W-1:0] : DIV_CYCLES[CNT_W-1:0];
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
        end else if (count_q == CNT_W'(1)) begin
            count_d = '0;
            hi_d    = pend_hi_q;
            lo_d    = pend_lo_q;
        end else if (!idle) begin
            count_d = count_q - CNT_W'(1);
        end else if (!start) begin
            if (op == MD_MTHI) hi_d = A;
            if (op == MD_MTLO) lo_d = A;
        end
    end

    // State registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // MFHI/MFLO read mux; architectural values only, never the pending result
    always_comb begin
        md_out = 32'd0;
        case (op)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of arithmetic vectors plus
// hand-written sequences for divide-by-zero, busy interaction and async reset.
module tb_md_unit;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam int         N_MUL    = 5;
    localparam int         N_DIV    = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic [31:0] md_out;

    int          total;
    int          bad;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
        string       name;
    } vec_t;

    vec_t vecs[7];

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .start  (start),
        .A      (a_in),
        .B      (b_in),
        .busy   (busy),
        .md_out (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic read_reg(input logic [3:0] op, output logic [31:0] v);
        logic [3:0] saved;
        saved = md_op;
        md_op = op;
        #1;
        v = md_out;
        md_op = saved;
    endtask

    // Issue one md operation and check busy window, pre-commit and post-commit HI/LO
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int n,
                          input string name);
        logic [31:0] v;
        int          busy_cnt;
        md_op = op;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        md_op = OP_NONE;
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (busy) busy_cnt++;
            if (i == n - 1) begin
                read_reg(OP_MFHI, v);
                check({name, " hi before commit"}, v, model_hi);
                read_reg(OP_MFLO, v);
                check({name, " lo before commit"}, v, model_lo);
            end
            tick();
        end
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(n));
        check({name, " busy after commit"}, {31'd0, busy}, 32'd0);
        read_reg(OP_MFHI, v);
        check({name, " hi"}, v, ehi);
        read_reg(OP_MFLO, v);
        check({name, " lo"}, v, elo);
        model_hi = ehi;
        model_lo = elo;
    endtask

    initial begin
        logic [31:0] v;
        total    = 0;
        bad      = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        reset    = 1'b0;
        md_op    = OP_NONE;
        start    = 1'b0;
        a_in     = 32'd0;
        b_in     = 32'd0;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, N_MUL, "mult -2*3"};
        vecs[1] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, N_DIV, "div -7/2"};
        vecs[2] = '{OP_DIVU,  32'hFFFF_FFF9, 32'd2,        32'd1,         32'h7FFF_FFFC, N_DIV, "divu"};
        vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, N_DIV, "div ovf"};
        vecs[4] = '{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, N_MUL, "mult max*min"};
        vecs[5] = '{OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, N_DIV, "div 100/-7"};
        vecs[6] = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        N_DIV, "divu small"};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        read_reg(OP_MFHI, v);
        check("reset hi", v, 32'd0);
        read_reg(OP_MFLO, v);
        check("reset lo", v, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n,
                   vecs[i].name);
        end

        // Divide by zero leaves preloaded HI/LO untouched
        md_op = OP_MTHI;
        a_in  = 32'h1234;
        tick();
        md_op = OP_MTLO;
        a_in  = 32'h5678;
        tick();
        md_op = OP_NONE;
        model_hi = 32'h1234;
        model_lo = 32'h5678;
        read_reg(OP_MFHI, v);
        check("mthi", v, 32'h1234);
        read_reg(OP_MFLO, v);
        check("mtlo", v, 32'h5678);
        run_op(OP_DIVU, 32'h99, 32'd0, 32'h1234, 32'h5678, N_DIV, "divu by zero");

        // start and MTLO while busy are ignored
        md_op = OP_MULTU;
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        md_op = OP_NONE;
        tick();
        md_op = OP_DIV;
        a_in  = 32'd100;
        b_in  = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        md_op = OP_MTLO;
        a_in  = 32'hDEAD;
        tick();
        md_op = OP_NONE;
        check("busy ia after edge3", {31'd0, busy}, 32'd1);
        tick();
        check("busy ia after edge4", {31'd0, busy}, 32'd1);
        read_reg(OP_MFLO, v);
        check("busy ia mtlo ignored", v, model_lo);
        tick();
        check("busy ia done after edge5", {31'd0, busy}, 32'd0);
        read_reg(OP_MFHI, v);
        check("busy ia hi", v, 32'hFFFF_FFFE);
        read_reg(OP_MFLO, v);
        check("busy ia lo", v, 32'h0000_0001);
        model_hi = 32'hFFFF_FFFE;
        model_lo = 32'h0000_0001;

        // Asynchronous reset in the middle of a MULT
        md_op = OP_MULT;
        a_in  = 32'd5;
        b_in  = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        md_op = OP_NONE;
        tick();
        tick();
        check("busy before async reset", {31'd0, busy}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        read_reg(OP_MFHI, v);
        check("async reset hi", v, 32'd0);
        read_reg(OP_MFLO, v);
        check("async reset lo", v, 32'd0);
        reset = 1'b1;
        md_op = OP_MTHI;
        a_in  = 32'hAA;
        tick();
        md_op = OP_NONE;
        check("post reset busy", {31'd0, busy}, 32'd0);
        read_reg(OP_MFHI, v);
        check("post reset mthi", v, 32'hAA);
        read_reg(OP_MFLO, v);
        check("post reset lo", v, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
